// File: rtl/serial_bus_arbiter_if.sv
// Bus signals between the single-wire bus masters and the arbiter.
// Request/grant: a master holds mreq high for its whole transaction; the arbiter
// answers with a registered one-hot mgrant; dropping mreq ends the ownership.
interface serial_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] mreq;
    logic                   slave_busy;
    logic [NUM_MASTERS-1:0] mgrant;
    logic                   bus_util;
    logic [ID_WIDTH-1:0]    owner_id;
    logic                   timeout_pulse;
    logic [ID_WIDTH-1:0]    timeout_id;

    modport master (
        output mreq, slave_busy,
        input  mgrant, bus_util, owner_id, timeout_pulse, timeout_id
    );

    modport slave (
        input  mreq, slave_busy,
        output mgrant, bus_util, owner_id, timeout_pulse, timeout_id
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin owner arbiter for the shared serial bus, with a mandatory idle gap
// between owners and a hang watchdog that evicts and masks a stuck master.
module serial_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 64,
    parameter int ID_WIDTH    = $clog2(NUM_MASTERS)
) (
    input  logic                clk,
    input  logic                rstn,
    serial_bus_arbiter_if.slave bus,
    output logic [1:0]          dbg_state
);
    localparam int CNT_WIDTH = $clog2(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]             state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [ID_WIDTH-1:0]    last_owner;
    logic [ID_WIDTH-1:0]    owner_id;
    logic [ID_WIDTH-1:0]    timeout_id;
    logic [ID_WIDTH-1:0]    sel;
    logic [ID_WIDTH-1:0]    cand;
    logic [NUM_MASTERS-1:0] req_mask;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] mgrant;
    logic [NUM_MASTERS-1:0] mask_set;
    logic                   bus_util;
    logic                   timeout_pulse;
    logic                   found;
    logic                   owner_req;
    logic                   force_release;

    assign eligible  = bus.mreq & ~req_mask;
    assign owner_req = bus.mreq[owner_id];

    // The watchdog only fires when the owner is still requesting and the slave is quiet.
    assign force_release = (state == ST_BUSY) && owner_req && !bus.slave_busy && (cnt == CNT_LIMIT);
    assign mask_set      = force_release ? (NUM_MASTERS'(1) << owner_id) : '0;

    // Search starts just after the previous owner, so the last winner ranks lowest.
    always_comb begin
        sel   = last_owner;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = ID_WIDTH'((int'(last_owner) + i) % NUM_MASTERS);
            if (!found && eligible[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            last_owner    <= ID_WIDTH'(NUM_MASTERS - 1);
            owner_id      <= '0;
            timeout_id    <= '0;
            req_mask      <= '0;
            mgrant        <= '0;
            bus_util      <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            req_mask      <= (req_mask & bus.mreq) | mask_set;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        mgrant     <= NUM_MASTERS'(1) << sel;
                        bus_util   <= 1'b1;
                        owner_id   <= sel;
                        last_owner <= sel;
                        cnt        <= '0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!owner_req) begin
                        mgrant   <= '0;
                        bus_util <= 1'b0;
                        state    <= ST_RELEASE;
                    end else if (bus.slave_busy) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LIMIT) begin
                        mgrant        <= '0;
                        bus_util      <= 1'b0;
                        timeout_pulse <= 1'b1;
                        timeout_id    <= owner_id;
                        state         <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    mgrant   <= '0;
                    bus_util <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mgrant        = mgrant;
    assign bus.bus_util      = bus_util;
    assign bus.owner_id      = owner_id;
    assign bus.timeout_pulse = timeout_pulse;
    assign bus.timeout_id    = timeout_id;
    assign dbg_state         = state;
endmodule
